// File: rtl/nucleotide_pack4.sv
// Streaming packer: ASCII nucleotides in, four 2-bit codes per output byte out.
// Invalid characters are dropped and counted; in_last always closes the sequence with a beat.
module nucleotide_pack4 #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_char,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [7:0]           out_byte,
    output logic [2:0]           out_count,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [7:0] acc;
    logic [1:0] cnt;
    logic [7:0] acc_n;
    logic [1:0] cnt_n;

    logic       accept;
    logic       char_ok;
    logic [1:0] code;
    logic [7:0] merged;

    logic       load;
    logic [7:0] ld_byte;
    logic [2:0] ld_count;
    logic       ld_last;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        char_ok = 1'b1;
        code    = 2'b00;
        case (in_char)
            8'h41, 8'h61: code = 2'b00;
            8'h43, 8'h63: code = 2'b01;
            8'h47, 8'h67: code = 2'b10;
            8'h54, 8'h74: code = 2'b11;
            default: begin
                char_ok = 1'b0;
                code    = 2'b00;
            end
        endcase
    end

    // Slots above cnt are always zero, so OR-ing the shifted code is a slot write.
    assign merged = acc | ({6'b0, code} << {cnt, 1'b0});

    always_comb begin
        acc_n    = acc;
        cnt_n    = cnt;
        load     = 1'b0;
        ld_byte  = '0;
        ld_count = '0;
        ld_last  = 1'b0;
        if (accept) begin
            if (char_ok) begin
                if (cnt == 2'd3 || in_last) begin
                    load     = 1'b1;
                    ld_byte  = merged;
                    ld_count = 3'(cnt) + 3'd1;
                    ld_last  = in_last;
                    acc_n    = '0;
                    cnt_n    = '0;
                end else begin
                    acc_n = merged;
                    cnt_n = cnt + 2'd1;
                end
            end else if (in_last) begin
                load     = 1'b1;
                ld_byte  = acc;
                ld_count = 3'(cnt);
                ld_last  = 1'b1;
                acc_n    = '0;
                cnt_n    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_n;
            cnt <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_byte  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_byte  <= ld_byte;
            out_count <= ld_count;
            out_last  <= ld_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && !char_ok;
            if (accept && !char_ok && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
